// File: rtl/arb4_rr_pkg.sv
// arb4_rr_pkg: shared state encoding, hold-limit default and one-hot helper for the 4-way arbiter
package arb4_rr_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
    localparam int MAX_HOLD_DEFAULT = 16;
    localparam logic [7:0] HCNT_SAT = 8'hFF;
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotate-and-pick, returns the first requester at or after ptr (mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);
    logic [3:0] rot;
    logic [1:0] off;
    always_comb begin
        rot = 4'({req, req} >> ptr);
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx = ptr + off;
        any = |req;
    end
endmodule

// File: rtl/arb4_rr.sv
// arb4_rr: 4-requester round-robin arbiter with hold limit, timeout pulse and back-to-back re-grant
module arb4_rr
    import arb4_rr_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);
    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d, sel_q, sel_d, arb_ptr, win;
    logic [7:0] hcnt_q, hcnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d, to_q, to_d, any, at_limit, release_c;
    // while granted, arbitrate as if ptr had already moved past the holder
    assign arb_ptr = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
    rr_pick4 u_pick (.req(req), .ptr(arb_ptr), .any(any), .idx(win));
    always_comb begin
        at_limit  = hcnt_q == 8'(MAX_HOLD - 1);
        release_c = (state_q == GRANT) && (done || !req[sel_q] || at_limit);
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        to_d      = 1'b0;
        if (state_q == IDLE || release_c) begin
            ptr_d   = release_c ? sel_q + 2'd1 : ptr_q;
            to_d    = release_c && !done && req[sel_q] && at_limit;
            state_d = any ? GRANT : IDLE;
            sel_d   = any ? win : sel_q;
            gnt_d   = any ? onehot4(win) : 4'b0000;
            busy_d  = any;
            hcnt_d  = 8'd0;
        end else begin
            hcnt_d = (hcnt_q == HCNT_SAT) ? hcnt_q : hcnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            hcnt_q  <= 8'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end
    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = to_q;
endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: directed scenarios plus randomized req/done, scored against an integer-level arbiter model
module tb_arb4_rr;
    localparam int MH = 4;
    localparam int STARVE = 3 * MH + 4;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy, timeout;
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;
    exp_t q[$];
    int m_hold = -1;
    int m_last = 0;
    int m_prio = 0;
    int m_held = 0;
    int wait_c[4] = '{0, 0, 0, 0};

    arb4_rr #(.MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // reference: integer holder/priority bookkeeping, one expectation per clock edge
    always @(posedge clk) begin
        exp_t e;
        int   nh;
        logic mto;
        mto = 1'b0;
        if (reset) begin
            m_hold = -1; m_last = 0; m_prio = 0; m_held = 0;
        end else if (m_hold < 0) begin
            nh = pick(req, m_prio);
            if (nh >= 0) begin m_hold = nh; m_last = nh; m_held = 0; end
        end else if (done || !req[m_hold] || m_held == MH - 1) begin
            mto = !done && req[m_hold] && (m_held == MH - 1);
            m_prio = (m_hold + 1) % 4;
            nh = pick(req, m_prio);
            m_hold = nh;
            if (nh >= 0) begin m_last = nh; m_held = 0; end
        end else if (m_held < 255) begin
            m_held++;
        end
        e.gnt  = (m_hold >= 0) ? 4'(1 << m_hold) : 4'b0000;
        e.sel  = 2'(m_last);
        e.busy = m_hold >= 0;
        e.to   = mto;
        q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = q.pop_front();
            if ({gnt, sel, busy, timeout} !== e) begin
                errors++;
                $display("FAIL scoreboard: got gnt=%b sel=%0d busy=%b to=%b expected gnt=%b sel=%0d busy=%b to=%b at %0t",
                         gnt, sel, busy, timeout, e.gnt, e.sel, e.busy, e.to, $time);
            end
        end
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (busy) chk("gnt_vs_sel", 32'(gnt), 32'(4'b0001 << sel));
        for (int i = 0; i < 4; i++) begin
            wait_c[i] = (!reset && req[i] && !gnt[i]) ? wait_c[i] + 1 : 0;
            if (wait_c[i] > STARVE) begin
                chk("starve", 32'(wait_c[i]), 32'(STARVE));
                wait_c[i] = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        req = 4'b1010;
        sample();
        chk("first_gnt", 32'(gnt), 32'b0010);
        chk("first_sel", 32'(sel), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        @(negedge clk); req = 4'b0000;
        sample();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sel", 32'(sel), 32'd1);
        @(negedge clk); done = 1'b1;
        sample();
        chk("idle_done", 32'(gnt), 32'd0);
        do_reset();
        req = 4'b1111; done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("rr_order", 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk("rr_busy", 32'(busy), 32'd1);
        end
        do_reset();
        req = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            sample();
            chk("hold_gnt", 32'(gnt), 32'b0100);
            chk("hold_to", 32'(timeout), 32'(k == 5));
        end
        do_reset();
        req = 4'b1010;
        sample();
        chk("drop_gnt0", 32'(gnt), 32'b0010);
        @(negedge clk); req = 4'b1000;
        sample();
        chk("drop_gnt", 32'(gnt), 32'b1000);
        chk("drop_sel", 32'(sel), 32'd3);
        @(negedge clk); req = 4'b0000;
        sample();
        chk("drop_idle", 32'({gnt, busy}), 32'd0);
        chk("drop_sel_hold", 32'(sel), 32'd3);
        @(negedge clk); req = 4'b1111;
        repeat (2) sample();
        chk("mid_pre", 32'(busy), 32'd1);
        @(negedge clk); reset = 1'b1;
        sample();
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        sample();
        chk("after_rst", 32'(gnt), 32'b0001);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        req = 4'b0000; done = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb4_rr.md
ARB4_RR -- requirements
Module: arb4_rr

Interface
REQ-001 Parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles before forced release (legal range 2..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i = requester i wants the shared resource.
REQ-005 done  input  1  holder signals end of its transfer; sampled only while busy.
REQ-006 gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 sel  output  2  registered binary index of current or most recent holder; drives the 4-way mux/demux select.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 States SHALL be IDLE and GRANT, plus a 2-bit priority pointer ptr and an 8-bit hold counter hcnt.
REQ-011 Winner SHALL be the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE with req != 0 at edge N: from cycle N+1, gnt = onehot(winner), sel = winner, busy = 1, hcnt = 0, state = GRANT.
REQ-013 IDLE with req == 0: gnt = 0, busy = 0, sel holds previous value.
REQ-014 GRANT: hcnt SHALL increment each cycle the grant is held (saturating at 255).
REQ-015 Release condition in GRANT: done = 1, or req[sel] = 0, or hcnt == MAX_HOLD-1.
REQ-016 On release at edge N, ptr SHALL become sel+1 (mod 4), so the releasing holder gets lowest priority.
REQ-017 On release at edge N, if req (at edge N, holder bit included) != 0, arbitration SHALL use the new ptr and the new grant SHALL appear at N+1 with no idle cycle; otherwise state = IDLE, gnt = 0 at N+1.
REQ-018 A sole requester that releases while still requesting SHALL be re-granted at N+1 with hcnt = 0.
REQ-019 timeout SHALL pulse at N+1 only if release was caused solely by hcnt == MAX_HOLD-1 (done = 0, req[sel] = 1).
REQ-020 gnt SHALL never have more than one bit set; gnt SHALL equal onehot(sel) whenever busy = 1.
REQ-021 done while IDLE SHALL be ignored.
REQ-022 Request changes of non-holders during GRANT SHALL NOT affect gnt until release.

Reset
REQ-023 reset at edge N SHALL force, at N+1: state IDLE, gnt = 0, sel = 0, busy = 0, timeout = 0, ptr = 0, hcnt = 0, regardless of state or inputs, including mid-grant.
REQ-024 First arbitration after reset SHALL give requester 0 highest priority.

Structure
REQ-025 State encodings (IDLE=0, GRANT=1) and MAX_HOLD default SHALL live in a shared include file used by all sequencing blocks.
REQ-026 Combinational rotate-and-pick logic SHALL be a sub-module rr_pick4 (inputs req, ptr; outputs any, idx[1:0]).
REQ-027 All outputs SHALL be driven directly from flops.

Verification
REQ-028 Reset then req=4'b1010 -> next cycle gnt=4'b0010, sel=1, busy=1.
REQ-029 req=4'b1111 held, done pulsed each grant -> grant order 0,1,2,3,0 with no idle cycles between.
REQ-030 MAX_HOLD=4, req=4'b0100 held, done=0 -> gnt=4'b0100 for 4 cycles, timeout pulse, immediate re-grant to 2.
REQ-031 Holder 1 drops req while req[3]=1 -> next cycle gnt=4'b1000, sel=3; later req=0 -> gnt=0, busy=0, sel stays 3.
REQ-032 reset asserted mid-grant with req=4'b1111 -> gnt=0, sel=0, then gnt=4'b0001 the cycle after reset deasserts.
REQ-033 Random req/done for 10k cycles -> assert gnt one-hot-or-zero, gnt==onehot(sel) when busy, no requester starved beyond 3*MAX_HOLD+4 cycles.
